// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back scheduler.
// Contents:
//   XLEN / NREG / AW   data width, architectural register count, index width
//   SRC_ALU / SRC_MEM  write-back source indices (bit positions in grant vectors)
//   wb_req_t           one write-back request {valid, rd, data}
//   src_hazard()       RAW check for one source operand
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // A source operand is hazardous while its register has an outstanding
    // write, or during the one cycle where the busy bit has already cleared
    // but the register file has not yet absorbed the write. x0 never stalls.
    function automatic logic src_hazard(input logic [AW-1:0]   rs,
                                        input logic [NREG-1:0] busy,
                                        input logic            wr_en,
                                        input logic [AW-1:0]   wr_rd);
        return (rs != '0) && (busy[rs] || (wr_en && (wr_rd == rs)));
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of all decode, write-back and register-file signals of the
// write-back scheduler.
//   master: decode + execute/memory units + register file (drives requests)
//   slave : the scheduler (drives readies, hazard, rf write port, busy, error)
interface regfile_wb_scheduler_if;
    import regfile_pkg::*;

    // Decode issue / hazard check
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            hazard;

    // Write-back requesters
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    // Register-file write port and status
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [NREG-1:0] busy;
    logic            protocol_err;

    modport master (
        output issue_valid, issue_rd, chk_rs1, chk_rs2,
               alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  issue_ready, hazard, alu_ready, mem_ready,
               rf_we, rf_rd, rf_wd, busy, protocol_err
    );

    modport slave (
        input  issue_valid, issue_rd, chk_rs1, chk_rs2,
               alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output issue_ready, hazard, alu_ready, mem_ready,
               rf_we, rf_rd, rf_wd, busy, protocol_err
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   valid_i     request vector, bit SRC_ALU / SRC_MEM
//   grant_o     one-hot (or zero) grant, combinational from valid_i and prio
// The priority bit only moves when both sources compete, so a lone requester
// never disturbs fairness for the next contention.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        prio_d  = prio_q;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                grant_o[prio_q] = 1'b1;
                prio_d          = ~prio_q;
            end
            default: grant_o = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= SRC_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard for the 32x32 register file.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   wb_if       slave side of regfile_wb_scheduler_if:
//     issue_valid/issue_rd/issue_ready  decode issue, stalls on WAW
//     chk_rs1/chk_rs2/hazard            RAW stall check for decode
//     alu_* / mem_*                     write-back requests, round-robin shared
//     rf_we/rf_rd/rf_wd                 registered register-file write port
//     busy                              registered scoreboard, bit 0 always 0
//     protocol_err                      sticky: write-back to a non-busy reg
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_scheduler_if.slave  wb_if
);

    wb_req_t         alu_req;
    wb_req_t         mem_req;
    logic [1:0]      grant;
    logic            any_grant;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            issue_hs;

    logic [NREG-1:0] busy_q,  busy_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;
    logic            perr_q,  perr_d;

    assign alu_req = '{valid: wb_if.alu_valid, rd: wb_if.alu_rd, data: wb_if.alu_data};
    assign mem_req = '{valid: wb_if.mem_valid, rd: wb_if.mem_rd, data: wb_if.mem_data};

    wb_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i ({mem_req.valid, alu_req.valid}),
        .grant_o (grant)
    );

    assign any_grant       = |grant;
    assign win_rd          = grant[SRC_MEM] ? mem_req.rd   : alu_req.rd;
    assign win_data        = grant[SRC_MEM] ? mem_req.data : alu_req.data;

    assign wb_if.alu_ready   = grant[SRC_ALU];
    assign wb_if.mem_ready   = grant[SRC_MEM];
    assign wb_if.issue_ready = ~busy_q[wb_if.issue_rd];
    assign issue_hs          = wb_if.issue_valid & wb_if.issue_ready;

    assign wb_if.hazard = src_hazard(wb_if.chk_rs1, busy_q, rf_we_q, rf_rd_q)
                        | src_hazard(wb_if.chk_rs2, busy_q, rf_we_q, rf_rd_q);

    always_comb begin
        busy_d  = busy_q;
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        perr_d  = perr_q;

        if (any_grant) begin
            rf_we_d = (win_rd != '0);
            rf_rd_d = win_rd;
            rf_wd_d = win_data;
            if (win_rd != '0) begin
                busy_d[win_rd] = 1'b0;
                // The write still goes through; the flag only reports it.
                if (!busy_q[win_rd]) begin
                    perr_d = 1'b1;
                end
            end
        end

        // Applied after the clear: a well-behaved pipeline never targets the
        // same register with both, and if a stray write-back does, the newer
        // issue must keep its reservation.
        if (issue_hs && (wb_if.issue_rd != '0)) begin
            busy_d[wb_if.issue_rd] = 1'b1;
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
            perr_q  <= perr_d;
        end
    end

    assign wb_if.busy         = busy_q;
    assign wb_if.rf_we        = rf_we_q;
    assign wb_if.rf_rd        = rf_rd_q;
    assign wb_if.rf_wd        = rf_wd_q;
    assign wb_if.protocol_err = perr_q;

endmodule
